grid_raster_scanner: RTL and testbench

GRID_RASTER_SCANNER -- requirements
Module: grid_raster_scanner

---
 rtl/grid_raster_scanner.sv | 128 ++++++++++++
 tb/tb_grid_raster_scanner.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_raster_scanner.sv
// Grid coordinate scanner: walks a sizeX x sizeY grid with a valid/ready stream.
// Define GRID_SCAN_SERPENTINE_EN for boustrophedon order; raster order otherwise.
module grid_raster_scanner (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] in_sizestring,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [6:0]  out_x,
    output logic [6:0]  out_y,
    output logic [13:0] out_index,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err_size
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [6:0]  sx_q, sy_q;
    logic [6:0]  x_q, y_q, x_d, y_d;
    logic [13:0] idx_q, idx_d;
    logic        done_q, err_q;
    logic        row_end;
    logic        last_cell;
    logic [6:0]  sx_in, sy_in;

    assign sx_in = in_sizestring[6:0];
    assign sy_in = in_sizestring[13:7];

`ifdef GRID_SCAN_SERPENTINE_EN
    logic odd_row;
    assign odd_row = y_q[0];

    // Odd rows run right-to-left; a turn keeps x and steps one full row.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        row_end = odd_row ? (x_q == 7'd0) : (x_q == sx_q - 7'd1);
        if (row_end) begin
            y_d   = y_q + 7'd1;
            idx_d = idx_q + {7'd0, sx_q};
        end else if (odd_row) begin
            x_d   = x_q - 7'd1;
            idx_d = idx_q - 14'd1;
        end else begin
            x_d   = x_q + 7'd1;
            idx_d = idx_q + 14'd1;
        end
    end
`else
    always_comb begin
        row_end = (x_q == sx_q - 7'd1);
        x_d     = row_end ? 7'd0 : x_q + 7'd1;
        y_d     = row_end ? y_q + 7'd1 : y_q;
        idx_d   = idx_q + 14'd1;
    end
`endif

    assign last_cell = row_end && (y_q == sy_q - 7'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sx_q    <= 7'd0;
            sy_q    <= 7'd0;
            x_q     <= 7'd0;
            y_q     <= 7'd0;
            idx_q   <= 14'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sx_q <= sx_in;
                        sy_q <= sy_in;
                        if (sx_in == 7'd0 || sy_in == 7'd0) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                            x_q     <= 7'd0;
                            y_q     <= 7'd0;
                            idx_q   <= 14'd0;
                        end
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        if (last_cell) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            x_q   <= x_d;
                            y_q   <= y_d;
                            idx_q <= idx_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state_q == SCAN);
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_index = idx_q;
    assign out_last  = (state_q == SCAN) && last_cell;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err_size  = err_q;

endmodule

// File: tb/tb_grid_raster_scanner.sv
// Scoreboard bench for grid_raster_scanner; the expected order follows
// GRID_SCAN_SERPENTINE_EN when it is defined.
module tb_grid_raster_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] in_sizestring;
    logic        out_ready;
    logic        out_valid;
    logic [6:0]  out_x;
    logic [6:0]  out_y;
    logic [13:0] out_index;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err_size;

    int checks = 0;
    int errors = 0;

    logic [28:0] sb_q[$];

    always #5 clk = ~clk;

    grid_raster_scanner dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_sizestring (in_sizestring),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_index     (out_index),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done),
        .err_size      (err_size)
    );

    function automatic logic [28:0] cur_cell();
        return {out_last, out_x, out_y, out_index};
    endfunction

    task automatic push_scan(input int sx, input int sy);
        int x;
        for (int y = 0; y < sy; y++) begin
            for (int k = 0; k < sx; k++) begin
                x = k;
`ifdef GRID_SCAN_SERPENTINE_EN
                if (y % 2 == 1) x = sx - 1 - k;
`endif
                sb_q.push_back({(y == sy - 1 && k == sx - 1),
                                7'(x), 7'(y), 14'(y * sx + x)});
            end
        end
    endtask

    task automatic do_start(input logic [13:0] size);
        @(negedge clk);
        start = 1'b1;
        in_sizestring = size;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_scan(input int sx, input int sy, input bit stall,
                            input bit junk, output int hs);
        logic [28:0] exp_c, prev_c;
        bit prev_stall;
        int cyc;
        int phase;
        hs = 0;
        cyc = 0;
        phase = 0;
        prev_stall = 0;
        prev_c = '0;
        sb_q.delete();
        push_scan(sx, sy);
        do_start({7'(sy), 7'(sx)});
        forever begin
            out_ready = stall ? (phase % 3 == 0) : 1'b1;
            phase++;
            if (junk) begin
                start = 1'b1;
                in_sizestring = 14'h0081;
            end
            checks++;
            if (out_valid !== 1'b1) begin
                $display("FAIL valid_mid_scan got %b exp 1", out_valid);
                errors++;
            end
            if (prev_stall) begin
                checks++;
                if (cur_cell() !== prev_c) begin
                    $display("FAIL stall_hold got %h exp %h", cur_cell(), prev_c);
                    errors++;
                end
            end
            if (out_valid && out_ready) begin
                exp_c = sb_q.pop_front();
                hs++;
                checks++;
                if (cur_cell() !== exp_c) begin
                    $display("FAIL cell got %h exp %h", cur_cell(), exp_c);
                    errors++;
                end
                if (sb_q.size() == 0) begin
                    start = 1'b0;
                    break;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_c = cur_cell();
            cyc++;
            if (cyc > sx * sy * 4 + 20) begin
                $display("FAIL scan_timeout got %0d left exp 0", sb_q.size());
                errors++;
                sb_q.delete();
                start = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        out_ready = 1'b1;
        checks++;
        if ({done, out_valid, busy} !== 3'b101) begin
            $display("FAIL done_cycle got %b exp 101", {done, out_valid, busy});
            errors++;
        end
        @(negedge clk);
        checks++;
        if ({done, out_valid, busy} !== 3'b000) begin
            $display("FAIL after_done got %b exp 000", {done, out_valid, busy});
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        in_sizestring = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_x, out_y, out_index, out_last, busy, done, err_size} !== '0) begin
            $display("FAIL reset_outputs got %h exp 0",
                     {out_valid, out_x, out_y, out_index, out_last, busy, done, err_size});
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_raster_3x2();
        int hs;
        run_scan(3, 2, 1'b0, 1'b0, hs);
        checks++;
        if (hs !== 6) begin
            $display("FAIL hs_3x2 got %0d exp 6", hs);
            errors++;
        end
    endtask

    task automatic test_stall();
        int hs;
        run_scan(3, 2, 1'b1, 1'b0, hs);
        checks++;
        if (hs !== 6) begin
            $display("FAIL hs_stall got %0d exp 6", hs);
            errors++;
        end
    endtask

    task automatic test_start_ignored();
        int hs;
        run_scan(4, 3, 1'b1, 1'b1, hs);
        checks++;
        if (hs !== 12) begin
            $display("FAIL hs_busy_start got %0d exp 12", hs);
            errors++;
        end
    endtask

    task automatic test_zero_size(input logic [13:0] size);
        do_start(size);
        checks++;
        if ({err_size, out_valid, busy} !== 3'b100) begin
            $display("FAIL err_pulse got %b exp 100", {err_size, out_valid, busy});
            errors++;
        end
        @(negedge clk);
        checks++;
        if ({err_size, out_valid, busy} !== 3'b000) begin
            $display("FAIL err_after got %b exp 000", {err_size, out_valid, busy});
            errors++;
        end
    endtask

    task automatic test_1x1();
        int hs;
        run_scan(1, 1, 1'b0, 1'b0, hs);
        checks++;
        if (hs !== 1) begin
            $display("FAIL hs_1x1 got %0d exp 1", hs);
            errors++;
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [28:0] exp_c;
        int hs;
        int cyc;
        sb_q.delete();
        push_scan(4, 4);
        do_start(14'h0204);
        out_ready = 1'b1;
        cyc = 0;
        while (cyc < 20) begin
            exp_c = sb_q.pop_front();
            checks++;
            if (cur_cell() !== exp_c) begin
                $display("FAIL pre_reset_cell got %h exp %h", cur_cell(), exp_c);
                errors++;
            end
            if (exp_c[13:0] == 14'd2) break;
            cyc++;
            @(negedge clk);
        end
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if ({out_valid, out_x, out_y, out_index, out_last, busy, done, err_size} !== '0) begin
            $display("FAIL mid_reset got %h exp 0",
                     {out_valid, out_x, out_y, out_index, out_last, busy, done, err_size});
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({done, out_valid, busy} !== 3'b000) begin
                $display("FAIL post_reset_idle got %b exp 000", {done, out_valid, busy});
                errors++;
            end
        end
        run_scan(2, 1, 1'b0, 1'b0, hs);
        checks++;
        if (hs !== 2) begin
            $display("FAIL hs_2x1 got %0d exp 2", hs);
            errors++;
        end
    endtask

    task automatic test_max_grid();
        int hs;
        run_scan(127, 127, 1'b0, 1'b0, hs);
        checks++;
        if (hs !== 16129) begin
            $display("FAIL hs_max got %0d exp 16129", hs);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_raster_3x2();
        test_stall();
        test_zero_size(14'h0100);
        test_zero_size(14'h0003);
        test_1x1();
        test_start_ignored();
        test_reset_mid_scan();
        test_max_grid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
